la_businv_dec: RTL and testbench

Bus-invert decoder and line-rule checker: receiving end of a bus-invert coded link, whose transmitter conditionally inverts a data word to limit line transitions and flags this with an invert bit. The block accepts encoded words over a valid/ready handshake and restores the original data by conditional inversion. It checks every received word against the bus-invert transition rule and forwards decoded words through a registered two-entry skid buffer. It sits in the stdlib next to the basic gates as the sequential companion for low-power inter-block buses.

---
 rtl/la_businv_dec.sv | 150 +++++++++++++++
 tb/tb_la_businv_dec.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_businv_dec.sv
// Bus-invert decoder with line-rule checking and a two-entry registered skid buffer.
// Restores inverted words, flags transitions above DW/2 bits, forwards in strict FIFO order.
//
// state    | meaning
// ST_EMPTY | output register and skid register both empty
// ST_ONE   | output register holds a word, skid register empty
// ST_FULL  | both registers hold words, in_ready held low
`timescale 1ns/1ps
module la_businv_dec #(
  parameter int DW   = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          err,
  output logic [7:0]    err_cnt,
  input  logic          err_clear
);

  localparam int HW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   line_q;
  logic [DW-1:0]   out_q;
  logic [DW-1:0]   skid_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            err_q;
  logic            err_d;
  logic [7:0]      cnt_q;
  logic [7:0]      cnt_d;

  logic            accept;
  logic            take;
  logic            viol;
  logic [DW-1:0]   dec;
  logic [HW-1:0]   hd;
  logic            unused_prop;

  // PROP carries an implementation hint only; it has no functional effect.
  assign unused_prop = |PROP;

  assign accept = in_valid & in_ready_q;
  assign take   = out_valid_q & out_ready;
  assign dec    = in_inv ? ~in_data : in_data;

  always_comb begin
    hd = '0;
    for (int i = 0; i < DW; i++) begin
      hd = hd + HW'(in_data[i] ^ line_q[i]);
    end
  end

  assign viol = accept && (hd > HW'(DW / 2));

  // A clear coinciding with a violation leaves exactly that one violation recorded.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clear) begin
      err_d = viol;
      cnt_d = viol ? 8'd1 : 8'd0;
    end else if (viol) begin
      err_d = 1'b1;
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_EMPTY;
      line_q      <= '0;
      out_q       <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        line_q <= in_data;
      end
      case (state_q)
        ST_EMPTY: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && take) begin
            out_q <= dec;
          end else if (accept) begin
            skid_q     <= dec;
            in_ready_q <= 1'b0;
            state_q    <= ST_FULL;
          end else if (take) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain of the skid is possible.
          if (take) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;
  assign err       = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_la_businv_dec.sv
// Self-checking bench for la_businv_dec (DW=8): directed scenarios plus randomized traffic
// against a queue-based reference of decode, line-rule and error-count behaviour.
`timescale 1ns/1ps
module tb_la_businv_dec;

  logic       clk;
  logic       nreset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_inv;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       err;
  logic [7:0] err_cnt;
  logic       err_clear;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_line;
  logic       m_err;
  logic [7:0] m_cnt;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  la_businv_dec #(.DW(8), .PROP("DEFAULT")) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err),
    .err_cnt   (err_cnt),
    .err_clear (err_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: handshakes observed mid-cycle take effect at the following rising edge.
  always @(negedge clk or negedge nreset) begin
    if (!nreset) begin
      m_line = 8'h00;
      m_err  = 1'b0;
      m_cnt  = 8'd0;
      exp_q.delete();
      got_q.delete();
    end else begin : mon
      bit v;
      v = 1'b0;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (in_valid && in_ready) begin
        exp_q.push_back(in_inv ? ~in_data : in_data);
        v = ($countones(in_data ^ m_line) > 4);
        m_line = in_data;
      end
      if (err_clear) begin
        m_err = v;
        m_cnt = v ? 8'd1 : 8'd0;
      end else if (v) begin
        m_err = 1'b1;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    #2;
    step();
    step();
    nreset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", err); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
    nreset = 1'b1;
    #2;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_no_edge_in_ready got %0b exp 0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_first_edge_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_decode_tie();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    in_data   = 8'h0F;
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tie_out_valid got %0b exp 1", out_valid); end
    checks++; if (out_data !== 8'h0F) begin errors++; $display("FAIL tie_out_data got %h exp 0f", out_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL tie_err got %0b exp 0", err); end
    in_inv  = 1'b1;
    in_data = 8'h0E;
    step();
    checks++; if (out_data !== 8'hF1) begin errors++; $display("FAIL inv_out_data got %h exp f1", out_data); end
    checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL inv_err got %0b/%0d exp 0/0", err, err_cnt); end
    in_valid = 1'b0;
    in_inv   = 1'b0;
    step();
  endtask

  task automatic test_violation();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    in_data   = 8'hFF;
    step();
    checks++; if (out_data !== 8'hFF || out_valid !== 1'b1) begin errors++; $display("FAIL viol_delivered got %h/%0b exp ff/1", out_data, out_valid); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL viol_err got %0b exp 1", err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL viol_err_cnt got %0d exp 1", err_cnt); end
    in_data = 8'hFE;
    step();
    checks++; if (err_cnt !== 8'd1 || err !== 1'b1) begin errors++; $display("FAIL viol_hd1_cnt got %0d/%0b exp 1/1", err_cnt, err); end
    checks++; if (out_data !== 8'hFE) begin errors++; $display("FAIL viol_hd1_data got %h exp fe", out_data); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    in_data   = 8'h11;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_a_in_ready got %0b exp 1", in_ready); end
    in_data = 8'h12;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_after_b_in_ready got %0b exp 0", in_ready); end
    in_data = 8'h13;
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_c_held_in_ready got %0b exp 0", in_ready); end
    checks++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_out got %h/%0b exp 11/1", out_data, out_valid); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bp_nothing_taken got %0d exp 0", got_q.size()); end
    out_ready = 1'b1;
    step();
    checks++; if (out_data !== 8'h12 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain1 got %h/%0b exp 12/1", out_data, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 8'h13 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_drain2 got %h/%0b exp 13/1", out_data, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_out_valid got %0b exp 0", out_valid); end
    checks++;
    if (got_q.size() != 3) begin
      errors++; $display("FAIL bp_count got %0d exp 3", got_q.size());
    end else if (got_q[0] !== 8'h11 || got_q[1] !== 8'h12 || got_q[2] !== 8'h13) begin
      errors++; $display("FAIL bp_order got %h %h %h exp 11 12 13", got_q[0], got_q[1], got_q[2]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_data = (i % 2 == 0) ? 8'hFF : 8'h00;
      step();
    end
    checks++; if (err_cnt !== 8'd255 || err !== 1'b1) begin errors++; $display("FAIL sat_reach got %0d/%0b exp 255/1", err_cnt, err); end
    in_data = 8'hFF;
    step();
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", err_cnt); end
    err_clear = 1'b1;
    in_data   = 8'h00;
    step();
    err_clear = 1'b0;
    in_valid  = 1'b0;
    checks++; if (err_cnt !== 8'd1 || err !== 1'b1) begin errors++; $display("FAIL clear_with_viol got %0d/%0b exp 1/1", err_cnt, err); end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    checks++; if (err_cnt !== 8'd0 || err !== 1'b0) begin errors++; $display("FAIL clear_alone got %0d/%0b exp 0/0", err_cnt, err); end
    step();
  endtask

  task automatic test_random();
    logic       stalled;
    logic [7:0] held;
    int         n;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_inv    = $urandom_range(1) != 0;
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(2) != 0);
      err_clear = ($urandom_range(49) == 0);
      stalled   = out_valid && !out_ready;
      held      = out_data;
      step();
      checks++;
      if (err !== m_err || err_cnt !== m_cnt) begin
        errors++;
        if (errors < 20) $display("FAIL rand_err cycle %0d got %0b/%0d exp %0b/%0d", i, err, err_cnt, m_err, m_cnt);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++;
          if (errors < 20) $display("FAIL rand_stable cycle %0d got %h/%0b exp %h/1", i, out_data, out_valid, held);
        end
      end
    end
    in_valid  = 1'b0;
    err_clear = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 8) begin
      step();
      n++;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain_timeout got %0b exp 0", out_valid); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < got_q.size(); k++) begin
        if (got_q[k] !== exp_q[k]) begin
          errors++; $display("FAIL rand_data idx %0d got %h exp %h", k, got_q[k], exp_q[k]);
          break;
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inv    = 1'b0;
    in_data   = 8'hF0;
    step();
    step();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got %0b/%0b exp 0/1", in_ready, out_valid); end
    #2;
    nreset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL mid_async got %0b/%0b/%h exp 0/0/00", out_valid, in_ready, out_data); end
    step();
    nreset = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got %0b exp 1", in_ready); end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h0F;
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 8'h0F || out_valid !== 1'b1) begin errors++; $display("FAIL mid_post_data got %h/%0b exp 0f/1", out_data, out_valid); end
    checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin errors++; $display("FAIL mid_line_cleared got %0b/%0d exp 0/0", err, err_cnt); end
    step();
  endtask

  initial begin
    nreset    = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    err_clear = 1'b0;
    test_reset();
    test_decode_tie();
    test_violation();
    test_backpressure();
    test_saturation();
    test_random();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
